// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MULDIV = 2'd1,
        HALT   = 2'd2
    } state_e;

    localparam int unsigned MULDIV_CYCLES_DEF = 4;
    localparam int unsigned REG_W             = 5;
    localparam int unsigned MD_CNT_W          = 8;
    localparam logic [REG_W-1:0] REG_ZERO     = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load currently in EX.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    output logic             load_use
);

    // $zero never carries a real dependency
    assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                      ((id_uses_rs && (id_rs == ex_rt)) ||
                       (id_uses_rt && (id_rt == ex_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: priority mux over halt, memory wait,
// mult/div occupancy, branch flush and load-use, plus a stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = MULDIV_CYCLES_DEF,
    parameter int unsigned CNT_BITS      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic                id_uses_rs,
    input  logic                id_uses_rt,
    input  logic                ex_mem_read,
    input  logic [REG_W-1:0]    ex_rt,
    input  logic                ex_branch_taken,
    input  logic                ex_muldiv_start,
    input  logic                mem_req,
    input  logic                mem_ack,
    input  logic                wb_halt,
    output logic                pc_en,
    output logic                ifid_en,
    output logic                idex_en,
    output logic                exmem_en,
    output logic                memwb_en,
    output logic                ifid_valid,
    output logic                idex_valid,
    output logic                exmem_valid,
    output logic                memwb_valid,
    output logic                halted,
    output logic [CNT_BITS-1:0] stall_count
);

    state_e              state_q;
    logic [MD_CNT_W-1:0] cnt_q;
    logic [CNT_BITS-1:0] stall_count_q;

    logic load_use;
    logic mem_stall;
    logic md_start;
    logic md_stall;

    load_use_detect u_load_use_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .load_use    (load_use)
    );

    // A taken branch squashes a mult/div issued alongside it
    assign mem_stall = mem_req && !mem_ack;
    assign md_start  = ex_muldiv_start && !ex_branch_taken;
    assign md_stall  = ((state_q == RUN) && md_start) ||
                       ((state_q == MULDIV) && (cnt_q != MD_CNT_W'(0)));

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_valid  = 1'b1;
        idex_valid  = 1'b1;
        exmem_valid = 1'b1;
        memwb_valid = 1'b1;
        halted      = 1'b0;
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_valid  = 1'b0;
            idex_valid  = 1'b0;
            exmem_valid = 1'b0;
            memwb_valid = 1'b0;
        end else if (state_q == HALT) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            halted   = 1'b1;
        end else if (mem_stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_valid = 1'b0;
        end else if (md_stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_valid = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_valid = 1'b0;
            idex_valid = 1'b0;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_valid = 1'b0;
        end
    end

    // cnt keeps draining under a memory stall; release at zero waits for it to clear
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            cnt_q         <= MD_CNT_W'(0);
            stall_count_q <= CNT_BITS'(0);
        end else begin
            if (!pc_en && (state_q != HALT)) begin
                stall_count_q <= stall_count_q + CNT_BITS'(1);
            end
            if (wb_halt) begin
                state_q <= HALT;
            end else begin
                case (state_q)
                    RUN: begin
                        if (md_start) begin
                            state_q <= MULDIV;
                            cnt_q   <= MD_CNT_W'(MULDIV_CYCLES - 1);
                        end
                    end
                    MULDIV: begin
                        if (cnt_q != MD_CNT_W'(0)) begin
                            cnt_q <= cnt_q - MD_CNT_W'(1);
                        end else if (!mem_stall) begin
                            state_q <= RUN;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and random checks of pipe_hazard_ctrl against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rs, id_uses_rt, ex_mem_read, ex_branch_taken;
    logic        ex_muldiv_start, mem_req, mem_ack, wb_halt;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_valid, idex_valid, exmem_valid, memwb_valid, halted;
    logic [31:0] stall_count;

    int          n_checks = 0;
    int          n_fail   = 0;

    // model: halt flag, mult/div occupancy and remaining front-end stall cycles
    bit          m_halt = 1'b0;
    bit          m_md   = 1'b0;
    int          m_left = 0;
    logic [31:0] m_count = '0;
    bit          m_known = 1'b0;
    logic [31:0] c0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MULDIV_CYCLES(N), .CNT_BITS(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .ex_muldiv_start (ex_muldiv_start),
        .mem_req         (mem_req),
        .mem_ack         (mem_ack),
        .wb_halt         (wb_halt),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .ifid_valid      (ifid_valid),
        .idex_valid      (idex_valid),
        .exmem_valid     (exmem_valid),
        .memwb_valid     (memwb_valid),
        .halted          (halted),
        .stall_count     (stall_count)
    );

    // {pc,ifid,idex,exmem,memwb}_en, {ifid,idex,exmem,memwb}_valid, halted
    function automatic logic [9:0] model_out();
        bit lu, mstall, mdst;
        lu = ex_mem_read && (ex_rt != 5'd0) &&
             ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
        mstall = mem_req && !mem_ack;
        mdst = m_md ? (m_left != 0) : (ex_muldiv_start && !ex_branch_taken);
        if (rst)             return 10'b00000_0000_0;
        if (m_halt)          return 10'b00000_1111_1;
        if (mstall)          return 10'b00001_1110_0;
        if (mdst)            return 10'b00011_1101_0;
        if (ex_branch_taken) return 10'b11111_0011_0;
        if (lu)              return 10'b00111_1011_0;
        return 10'b11111_1111_0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        rst = 1'b0; id_rs = '0; id_rt = '0; ex_rt = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; ex_muldiv_start = 1'b0;
        mem_req = 1'b0; mem_ack = 1'b0; wb_halt = 1'b0;
    endtask

    // one clock: check outputs mid-cycle, advance the model, return just after the edge
    task automatic tick(input string tag);
        logic [9:0] e;
        bit mstall;
        @(negedge clk);
        e = model_out();
        mstall = mem_req && !mem_ack;
        check({tag, "_out"}, 64'({pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                                  ifid_valid, idex_valid, exmem_valid, memwb_valid, halted}),
              64'(e));
        if (m_known) check({tag, "_cnt"}, 64'(stall_count), 64'(m_count));
        if (rst) begin
            m_halt = 1'b0; m_md = 1'b0; m_left = 0; m_count = '0; m_known = 1'b1;
        end else begin
            if (!e[9] && !m_halt) m_count = m_count + 32'd1;
            if (wb_halt) m_halt = 1'b1;
            else if (!m_halt) begin
                if (!m_md) begin
                    if (ex_muldiv_start && !ex_branch_taken) begin
                        m_md = 1'b1; m_left = N - 1;
                    end
                end else if (m_left != 0) m_left--;
                else if (!mstall) m_md = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        tick("rst0");
        tick("rst1");
        clr();
        check("rst_cnt", 64'(stall_count), 64'd0);
        tick("idle");

        // load-use on rs
        c0 = stall_count;
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        tick("lu_rs");
        check("lu_cnt", 64'(stall_count), 64'(c0 + 32'd1));
        clr(); tick("lu_after");

        // $zero destination never stalls
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        tick("lu_zero");
        // rt match, and rs match without use
        clr(); ex_mem_read = 1'b1; ex_rt = 5'd3; id_rt = 5'd3; id_uses_rt = 1'b1;
        tick("lu_rt");
        clr(); ex_mem_read = 1'b1; ex_rt = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b0;
        tick("lu_nouse");

        // branch wins over load-use
        clr(); ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        ex_branch_taken = 1'b1;
        tick("br_lu");
        clr();

        // mult/div pulse: 4 stall cycles, then free
        c0 = stall_count;
        ex_muldiv_start = 1'b1; tick("md0");
        ex_muldiv_start = 1'b0;
        for (int i = 1; i < 6; i++) tick("md");
        check("md_cnt", 64'(stall_count - c0), 64'd4);

        // mult/div with branch: branch wins
        ex_muldiv_start = 1'b1; ex_branch_taken = 1'b1; tick("md_br");
        clr(); tick("md_br_after");

        // mult/div with 6-cycle memory stall starting one cycle later
        ex_muldiv_start = 1'b1; tick("mdm0");
        ex_muldiv_start = 1'b0; mem_req = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 6; i++) tick("mdm_wait");
        mem_ack = 1'b1; tick("mdm_ack");
        clr(); tick("mdm_after");

        // memory request acked immediately: no stall
        mem_req = 1'b1; mem_ack = 1'b1; tick("mem_fast");
        clr();

        // reset while cnt = 2
        ex_muldiv_start = 1'b1; tick("mdr0");
        ex_muldiv_start = 1'b0; tick("mdr1");
        rst = 1'b1; tick("mdr_rst");
        check("mdr_cnt", 64'(stall_count), 64'd0);
        clr(); tick("mdr_after");

        // halt
        c0 = stall_count;
        wb_halt = 1'b1; tick("halt_req");
        wb_halt = 1'b0;
        for (int i = 0; i < 10; i++) tick("halted");
        check("halt_cnt", 64'(stall_count), 64'(c0));
        rst = 1'b1; tick("halt_rst");
        clr(); tick("halt_after");

        // randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            rst             = ($urandom_range(0, 39) == 0);
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_rt           = 5'($urandom_range(0, 3));
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            id_uses_rs      = 1'($urandom_range(0, 1));
            id_uses_rt      = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            ex_muldiv_start = ($urandom_range(0, 7) == 0);
            mem_req         = ($urandom_range(0, 2) == 0);
            mem_ack         = 1'($urandom_range(0, 1));
            wb_halt         = ($urandom_range(0, 149) == 0);
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall and flush controller for the 5-stage MIPS pipeline. It drives the `enable` and `valid` inputs of the four inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write-enable. It resolves four conditions:
- load-use hazards;
- taken-branch flushes;
- multi-cycle mult/div occupancy of EX;
- data-memory wait states.

It also latches a halt state on syscall-halt and counts stall cycles for performance reporting.

## Interface
Parameters:
- `MULDIV_CYCLES`, default 4: number of cycles the pipeline front stalls per mult/div. Legal range is 1..255.
- `CNT_BITS`, default 32: width of the stall-cycle counter.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk` in 1: system clock.
- `rst` in 1: synchronous reset, active-high.
- `id_rs`, `id_rt` in 5 each: source register numbers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt` in 1 each: the ID instruction reads that source.
- `ex_mem_read` in 1: the instruction in EX is a load.
- `ex_rt` in 5: destination register of that load.
- `ex_branch_taken` in 1: the EX instruction redirects the PC.
- `ex_muldiv_start` in 1: the EX instruction is a mult/div.
- `mem_req` in 1: the MEM stage is accessing data memory.
- `mem_ack` in 1: data memory completes the access this cycle.
- `wb_halt` in 1: the WB instruction is a halting syscall.
- `pc_en` out 1: PC write-enable.
- `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1 each: pipeline register enables. 0 means hold.
- `ifid_valid`, `idex_valid`, `exmem_valid`, `memwb_valid` out 1 each: pipeline register valid inputs. 0 means the register loads a bubble.
- `halted` out 1: the pipeline is frozen by halt.
- `stall_count` out `CNT_BITS`: number of cycles with `pc_en`=0 while not halted.

## Operation
FSM states:
- `RUN`: normal operation.
- `MULDIV`: a mult/div is holding EX.
- `HALT`: frozen until reset.

`cnt` is an 8-bit down-counter.

Outputs are combinational from state and inputs. The defaults are all `*_en`=1 and all `*_valid`=1. Overrides are applied in this priority order (highest first):
1. **`rst`=1:** all `*_en`=0, all `*_valid`=0, `halted`=0.
2. **State `HALT`:** all `*_en`=0, all `*_valid`=1, `halted`=1. The state exits only on `rst`.
3. **Memory stall** (`mem_req` && !`mem_ack`):
   - `pc_en`, `ifid_en`, `idex_en`, `exmem_en` = 0.
   - `memwb_valid`=0 (a bubble enters WB).
   - Branch and load-use conditions are ignored this cycle. They are re-evaluated because the EX and ID contents are held.
4. **Mult/div stall.** Applies in `RUN` with `ex_muldiv_start`, or in `MULDIV` with `cnt`≠0:
   - `pc_en`, `ifid_en`, `idex_en` = 0.
   - `exmem_valid`=0 (a bubble enters MEM).
   - MEM/WB keeps advancing.
5. **Taken branch** (`ex_branch_taken`): `ifid_valid`=0 and `idex_valid`=0; `pc_en`=1.
6. **Load-use.** Condition: `ex_mem_read` && `ex_rt`≠0 && ((`id_uses_rs` && `id_rs`==`ex_rt`) || (`id_uses_rt` && `id_rt`==`ex_rt`)). Action: `pc_en`=0, `ifid_en`=0, `idex_valid`=0.

State transitions (all are suppressed by `rst`):
- `RUN` → `MULDIV` when `ex_muldiv_start` && !`ex_branch_taken`. On this transition `cnt` loads `MULDIV_CYCLES`-1. This transition still occurs during a memory stall.
- `MULDIV`, `cnt`≠0: decrement `cnt` every cycle, including during a memory stall.
- `MULDIV`, `cnt`==0, no memory stall: release the mult/div stall this cycle and go to `RUN`.
- `MULDIV`, `cnt`==0, memory stall: hold the state until the memory stall clears.
- Any state → `HALT` when `wb_halt` && !`rst`.

Other rules:
- `ex_branch_taken` and `ex_muldiv_start` are mutually exclusive. If both are asserted, the branch wins and no mult/div stall occurs.
- `stall_count`:
  - Increments in every non-reset cycle with `pc_en`=0 and state ≠ `HALT`.
  - Wraps modulo 2^`CNT_BITS`.
  - Is cleared by `rst`.

## Timing
- Reset values: state=`RUN`, `cnt`=0, `stall_count`=0, `halted`=0. While `rst` is high, all enables and valids are 0.
- Load-use costs exactly 1 bubble. The following cycle sees the load in MEM, and the condition is false.
- A mult/div stalls the front end for exactly `MULDIV_CYCLES` cycles, with no memory stall. The mult/div occupies EX for `MULDIV_CYCLES`+1 cycles.
- Branch flush takes effect in the same cycle `ex_branch_taken` is asserted and costs 2 bubbles.
- Memory stall length is the number of cycles `mem_req` is high with `mem_ack` low. When `mem_ack` arrives together with `mem_req`, there is no stall.
- `HALT` is entered one cycle after `wb_halt` is sampled. In the cycle `wb_halt` is sampled, outputs are the normal `RUN` values.

## Structure
- Shared package `pipe_ctrl_pkg`:
  - state enum {`RUN`, `MULDIV`, `HALT`};
  - default `MULDIV_CYCLES`;
  - `REG_ZERO` = 5'd0.
- One natural combinational sub-module: `load_use_detect`. It takes the ID and EX fields and produces `load_use`.
- The FSM, the counters and the priority mux stay in the top module.

## Test plan
- **Load-use:** drive `ex_mem_read`=1, `ex_rt`=8, `id_rs`=8, `id_uses_rs`=1.
  - Same cycle: `pc_en`=0, `ifid_en`=0, `idex_valid`=0.
  - `stall_count` increases by 1.
  - Repeat with `ex_rt`=0: no stall occurs.
- **Branch plus load-use:** assert `ex_branch_taken`=1 together with the load-use condition above. Expect `pc_en`=1, `ifid_valid`=0, `idex_valid`=0.
- **Mult/div, `MULDIV_CYCLES`=4:** pulse `ex_muldiv_start` for 1 cycle.
  - `pc_en`=0 and `exmem_valid`=0 for exactly 4 cycles.
  - All outputs return to 1 on the 5th cycle.
  - `stall_count` is 4.
- **Memory stall during mult/div:** hold `mem_req`=1, `mem_ack`=0 for 6 cycles starting 1 cycle after mult/div start.
  - `exmem_en`=0 and `memwb_valid`=0 throughout the 6 cycles.
  - State stays `MULDIV` with `cnt`=0 until the ack arrives.
  - Release follows the ack.
- **Halt:** assert `wb_halt` for 1 cycle.
  - Next cycle: `halted`=1, all `*_en`=0, all `*_valid`=1.
  - `halted` holds for 10 cycles while `stall_count` stays unchanged.
  - Asserting `rst` clears everything.
- **Reset during mult/div:** assert `rst` while `cnt`=2.
  - Next cycle: state `RUN`, `stall_count`=0.
  - Outputs match the defaults once `rst` is released.
